// File: rtl/bit_serializer_pkg.sv
// Shared encodings and defaults for the bit serializer.
// The FSM benches import this package so they agree with the RTL.
package bit_serializer_pkg;

  localparam int SER_DEFAULT_WIDTH = 8;

  localparam logic SER_ENC_IDLE  = 1'b0;
  localparam logic SER_ENC_SHIFT = 1'b1;

  typedef enum logic {
    ST_IDLE  = SER_ENC_IDLE,
    ST_SHIFT = SER_ENC_SHIFT
  } ser_state_t;

  // Bits needed to hold a count from 0 up to and including width
  function automatic int ser_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Load/step handshake between an upstream word source, the serializer,
// and the downstream Moore FSM that consumes x_in.
interface bit_serializer_if
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = SER_DEFAULT_WIDTH
);

  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             step_en;
  logic             x_in;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid,
    output load_data,
    output step_en,
    input  load_ready,
    input  x_in,
    input  x_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  step_en,
    output load_ready,
    output x_in,
    output x_valid,
    output busy,
    output done
  );

endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial driver for the x_in port of the 2-bit Moore FSMs.
// One word in flight at a time; the consumer paces each bit with step_en.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = SER_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  bit_serializer_if.slave bus
);

  localparam int CNT_W = ser_cnt_w(WIDTH);

  localparam ser_state_t IDLE  = ST_IDLE;
  localparam ser_state_t SHIFT = ST_SHIFT;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  ser_state_t       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic             w_out_bit;

  // Move every bit one place toward the output end, zero-filling behind
  function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] v);
    if (MSB_FIRST)
      return {v[WIDTH-2:0], 1'b0};
    else
      return {1'b0, v[WIDTH-1:1]};
  endfunction

  // Decrement that saturates at zero
  function automatic logic [CNT_W-1:0] f_dec_sat(input logic [CNT_W-1:0] c);
    if (c == CNT_ZERO)
      return CNT_ZERO;
    else
      return c - CNT_ONE;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= CNT_ZERO;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.load_valid) begin
            r_shreg <= bus.load_data;
            r_cnt   <= CNT_LOAD;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          // load_valid is deliberately not looked at here: no overwrite, no queue
          if (bus.step_en) begin
            r_shreg <= f_shift(r_shreg);
            r_cnt   <= f_dec_sat(r_cnt);
            if (r_cnt == CNT_ONE) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, never on an input
  assign w_out_bit      = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign bus.x_in       = (r_state == SHIFT) & w_out_bit;
  assign bus.x_valid    = (r_state == SHIFT);
  assign bus.busy       = (r_state == SHIFT);
  assign bus.load_ready = (r_state == IDLE);
  assign bus.done       = r_done;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench: an LSB-first and an MSB-first serializer share one stimulus,
// and a small 2-bit Moore FSM consumes the LSB-first stream.
module tb_bit_serializer;
  import bit_serializer_pkg::*;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic fsm_rst = 1'b1;
  logic [1:0] fsm_q;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_acc   = 0;
  int t_prev  = 0;

  always #5 clock = ~clock;

  bit_serializer_if #(.WIDTH(8)) if_l ();
  bit_serializer_if #(.WIDTH(8)) if_m ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clock (clock),
    .reset (reset),
    .bus   (if_l)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clock (clock),
    .reset (reset),
    .bus   (if_m)
  );

  // Stand-in for the downstream 2-bit Moore FSM: s0 -1-> s3, s3 -0-> s3
  always @(posedge clock) begin
    if (fsm_rst) fsm_q <= 2'd0;
    else begin
      case (fsm_q)
        2'd0: fsm_q <= if_l.x_in ? 2'd3 : 2'd0;
        2'd3: fsm_q <= if_l.x_in ? 2'd1 : 2'd3;
        2'd1: fsm_q <= if_l.x_in ? 2'd2 : 2'd0;
        default: fsm_q <= if_l.x_in ? 2'd0 : 2'd3;
      endcase
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic s);
    if_l.load_valid = v; if_l.load_data = d; if_l.step_en = s;
    if_m.load_valid = v; if_m.load_data = d; if_m.step_en = s;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rdy_l"}, 32'(if_l.load_ready), 32'd1);
    check({tag, "_rdy_m"}, 32'(if_m.load_ready), 32'd1);
    check({tag, "_vld_l"}, 32'(if_l.x_valid), 32'd0);
    check({tag, "_vld_m"}, 32'(if_m.x_valid), 32'd0);
    check({tag, "_busy_l"}, 32'(if_l.busy), 32'd0);
    check({tag, "_busy_m"}, 32'(if_m.busy), 32'd0);
    check({tag, "_x_l"}, 32'(if_l.x_in), 32'd0);
    check({tag, "_x_m"}, 32'(if_m.x_in), 32'd0);
  endtask

  // el/em list the expected bits in emission order, first bit in [7].
  // hold: stall cycles after acceptance; inj_at: bit index at which 8'hFF is offered.
  task automatic run_word(input logic [7:0] d, input logic [7:0] el, input logic [7:0] em,
                          input string tag, input int hold, input int inj_at);
    drive(1'b1, d, (hold == 0));
    tick();
    t_acc = cyc;
    for (int h = 0; h < hold; h++) begin
      drive(1'b0, 8'h00, 1'b0);
      check($sformatf("%s_hold%0d_x_l", tag, h), 32'(if_l.x_in), 32'(el[7]));
      check($sformatf("%s_hold%0d_x_m", tag, h), 32'(if_m.x_in), 32'(em[7]));
      check($sformatf("%s_hold%0d_vld", tag, h), 32'(if_l.x_valid), 32'd1);
      check($sformatf("%s_hold%0d_cnt", tag, h), 32'(dut_l.r_cnt), 32'd8);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive((i == inj_at), (i == inj_at) ? 8'hFF : 8'h00, 1'b1);
      check($sformatf("%s_b%0d_x_l", tag, i), 32'(if_l.x_in), 32'(el[7-i]));
      check($sformatf("%s_b%0d_x_m", tag, i), 32'(if_m.x_in), 32'(em[7-i]));
      check($sformatf("%s_b%0d_vld_l", tag, i), 32'(if_l.x_valid), 32'd1);
      check($sformatf("%s_b%0d_busy_m", tag, i), 32'(if_m.busy), 32'd1);
      check($sformatf("%s_b%0d_rdy_l", tag, i), 32'(if_l.load_ready), 32'd0);
      check($sformatf("%s_b%0d_done_l", tag, i), 32'(if_l.done), 32'd0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b1);
    check({tag, "_done_l"}, 32'(if_l.done), 32'd1);
    check({tag, "_done_m"}, 32'(if_m.done), 32'd1);
    check({tag, "_done_rdy"}, 32'(if_l.load_ready), 32'd1);
    check({tag, "_done_vld"}, 32'(if_m.x_valid), 32'd0);
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_idle("rst");
    check("rst_done_l", 32'(if_l.done), 32'd0);
    check("rst_done_m", 32'(if_m.done), 32'd0);
    check("rst_cnt", 32'(dut_l.r_cnt), 32'd0);

    // step_en while idle must do nothing
    drive(1'b0, 8'h00, 1'b1);
    tick();
    tick();
    check_idle("idle_step");
    check("idle_step_cnt", 32'(dut_m.r_cnt), 32'd0);

    // A5 is a bit palindrome; 0F follows back-to-back from the done cycle
    run_word(8'hA5, 8'b1010_0101, 8'b1010_0101, "a5", 0, -1);
    t_prev = t_acc;
    run_word(8'h0F, 8'b1111_0000, 8'b0000_1111, "0f", 0, -1);
    check("b2b_period", 32'(t_acc - t_prev), 32'd9);
    tick();
    check("0f_done_gone", 32'(if_l.done), 32'd0);
    check_idle("0f_after");

    // Stall five cycles with step_en low right after loading 01
    run_word(8'h01, 8'b1000_0000, 8'b0000_0001, "hold01", 5, -1);
    tick();

    // 8'hFF offered mid-word must be ignored
    run_word(8'h00, 8'h00, 8'h00, "inj", 0, 3);
    tick();
    check_idle("inj_after");
    check("inj_done_gone", 32'(if_m.done), 32'd0);

    // Reset after three bits of C3, with a competing load offered
    drive(1'b1, 8'hC3, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("c3_b%0d_x_l", i), 32'(if_l.x_in), (i < 2) ? 32'd1 : 32'd0);
      check($sformatf("c3_b%0d_x_m", i), 32'(if_m.x_in), (i < 2) ? 32'd1 : 32'd0);
      tick();
    end
    reset = 1'b1;
    drive(1'b1, 8'hC3, 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    check_idle("abort");
    check("abort_done", 32'(if_l.done), 32'd0);
    check("abort_cnt", 32'(dut_l.r_cnt), 32'd0);
    tick();
    check("abort_done_next", 32'(if_l.done), 32'd0);
    check_idle("abort_next");
    run_word(8'h81, 8'b1000_0001, 8'b1000_0001, "81", 0, -1);
    tick();

    // Chain into the Moore FSM
    fsm_rst = 1'b0;
    tick();
    check("fsm_start", 32'(fsm_q), 32'd0);
    drive(1'b1, 8'h01, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fsm_b%0d_x", i), 32'(if_l.x_in), (i == 0) ? 32'd1 : 32'd0);
      check($sformatf("fsm_b%0d_state", i), 32'(fsm_q), (i == 0) ? 32'd0 : 32'd3);
      tick();
    end
    check("fsm_end_state", 32'(fsm_q), 32'd3);
    check("fsm_end_done", 32'(if_l.done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 0: 0 shifts LSB first, 1 shifts MSB first.
REQ-003 clock  input  1  Single clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  Synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 load_valid  input  1  Upstream offers a word on load_data.
REQ-006 load_data  input  WIDTH  Parallel word to serialize.
REQ-007 load_ready  output  1  Block can accept a word this cycle.
REQ-008 step_en  input  1  Downstream FSM consumes the presented bit this cycle.
REQ-009 x_in  output  1  Serial bit presented to the downstream FSM's x_in input.
REQ-010 x_valid  output  1  x_in carries a valid bit.
REQ-011 busy  output  1  Serialization in progress.
REQ-012 done  output  1  One-cycle pulse after the last bit is consumed.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE (encoding 0) and SHIFT (encoding 1).
REQ-014 In IDLE: load_ready=1, x_valid=0, busy=0, x_in=0.
REQ-015 A load SHALL be accepted on any rising edge with load_valid=1 and load_ready=1.
REQ-016 On acceptance: shift register <= load_data, bit counter <= WIDTH, state <= SHIFT.
REQ-017 In SHIFT: load_ready=0, x_valid=1, busy=1; load_valid SHALL be ignored (no overwrite, no queueing).
REQ-018 In SHIFT, x_in SHALL be shreg[0] when MSB_FIRST=0 and shreg[WIDTH-1] when MSB_FIRST=1.
REQ-019 x_in, x_valid and busy SHALL be driven combinationally from registered state only, with no path from any input.
REQ-020 On an edge in SHIFT with step_en=1, the register SHALL shift one position toward the output end, zero-filling, and the counter SHALL decrement by 1.
REQ-021 On an edge in SHIFT with step_en=0, the register, counter and state SHALL hold, so that x_in remains stable.
REQ-022 When step_en=1 at counter==1, state <= IDLE and done SHALL be 1 for exactly the following cycle.
REQ-023 First-bit latency: the first bit SHALL be valid in the cycle after load acceptance.
REQ-024 Minimum word period: WIDTH+1 cycles, consisting of WIDTH shift cycles plus 1 IDLE cycle.
REQ-025 In the done cycle, load_ready=1, so a new load may be accepted in that same cycle.
REQ-026 The counter width SHALL be clog2(WIDTH+1) bits, and the counter SHALL never underflow below 0.
REQ-027 step_en in IDLE SHALL have no effect.

Reset
REQ-028 When reset=1 at a clock edge, the block SHALL set: state=IDLE, shreg=0, counter=0, done=0.
REQ-029 reset SHALL take priority over load acceptance and step_en in the same cycle.
REQ-030 A reset asserted mid-word SHALL abort the word; no done pulse SHALL follow, and x_valid SHALL be 0 from the next cycle.
REQ-031 After reset: load_ready=1, x_valid=0, x_in=0, busy=0, done=0.

Structure
REQ-032 State encodings IDLE/SHIFT SHALL be localparams in the module.
REQ-033 The encodings SHALL be mirrored in a shared serializer_pkg header together with the default WIDTH, for reuse by the FSM bench.
REQ-034 The block SHALL be a single module with no sub-modules; the shift register and counter are inline.
REQ-035 The block SHALL be a drop-in driver for the x_in port of the existing 2-bit Moore FSMs, sharing their clock.

Verification
REQ-036 Reset then load 8'hA5 with MSB_FIRST=0 and step_en held at 1 -> x_in sequence 1,0,1,0,0,1,0,1 over 8 cycles, and done is high in cycle 9.
REQ-037 The same load 8'hA5 with MSB_FIRST=1 -> x_in sequence 1,0,1,0,0,1,0,1 (palindrome check); then load 8'h0F -> 0,0,0,0,1,1,1,1.
REQ-038 Load 8'h01, step_en low for 5 cycles after load -> x_in=1 and x_valid=1 held for all 5 cycles, and the counter is unchanged.
REQ-039 load_valid pulsed with 8'hFF mid-word while shifting 8'h00 -> all 8 output bits are 0, and 8'hFF is never emitted.
REQ-040 reset asserted after 3 bits of 8'hC3 -> IDLE next cycle, no done pulse, and a fresh load of 8'h81 serializes correctly.
REQ-041 Back-to-back load offered in the done cycle -> accepted, and the next word's first bit is valid on the following cycle (9-cycle period).
REQ-042 Chain the block into the 2-bit FSM: shift 8'b0000_0001 LSB-first -> the FSM leaves s0 to s3 after the first bit, then holds in s3 for the remaining 7 zero bits.
